// File: rtl/systolic_skew_feeder.sv
// Streams L words from a one-cycle registered-read SRAM into a systolic array,
// delaying lane r by r+1 stages to form the skewed wavefront.
module systolic_skew_feeder #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             srstn,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [LEN_WIDTH-1:0]             len,
  input  logic                             feed_stall,
  output logic [ADDR_WIDTH-1:0]            sram_raddr,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] sram_rdata,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] feed_data,
  output logic                             feed_valid,
  output logic                             busy,
  output logic                             done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_lastAddr;
  logic [LEN_WIDTH-1:0]    r_left;
  logic                    r_rdValid;
  logic [ARRAY_SIZE-1:0]   r_vld;
  logic [ARRAY_SIZE-1:0]   w_vldNext;
  logic [ADDR_WIDTH-1:0]   w_raddr;
  logic                    w_active;
  logic                    w_shift;
  logic                    w_drainEnd;
  logic                    w_clear;

  assign w_active   = (r_state == READ) || (r_state == DRAIN);
  assign w_shift    = w_active && !feed_stall;
  assign w_vldNext  = {r_vld[ARRAY_SIZE-2:0], r_rdValid};
  assign w_drainEnd = (r_state == DRAIN) && !feed_stall && (w_vldNext == '0);
  // Pipeline is wiped outside a run so no lane can leak words into the next one.
  assign w_clear    = !w_active || w_drainEnd;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_stateNext = (len == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (!feed_stall && (r_left == '0)) begin
          w_stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (w_drainEnd) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // On stall, re-present the address already in flight so sram_rdata stays put.
  always_comb begin
    w_raddr = '0;
    if (w_active) begin
      w_raddr = feed_stall ? r_lastAddr : r_addr;
    end
  end

  assign sram_raddr = w_raddr;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_addr     <= '0;
      r_left     <= '0;
      r_lastAddr <= '0;
      r_rdValid  <= 1'b0;
    end else begin
      r_lastAddr <= w_raddr;
      case (r_state)
        IDLE: begin
          r_rdValid <= 1'b0;
          if (start && (len != '0)) begin
            r_addr <= base_addr;
            r_left <= len - LEN_WIDTH'(1);
          end
        end
        READ: begin
          if (!feed_stall) begin
            r_rdValid <= 1'b1;
            if (r_left != '0) begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
              r_left <= r_left - LEN_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (!feed_stall) begin
            r_rdValid <= 1'b0;
          end
        end
        default: begin
          r_rdValid <= 1'b0;
        end
      endcase
    end
  end

  // r_vld[k] marks that stage k of every lane holds a real word (lane k's output).
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_vld <= '0;
    end else if (w_clear) begin
      r_vld <= '0;
    end else if (w_shift) begin
      r_vld <= w_vldNext;
    end
  end

  assign feed_valid = |r_vld;
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);

  for (genvar gLane = 0; gLane < ARRAY_SIZE; gLane++) begin : g_lane
    logic [DATA_WIDTH-1:0] r_stage [gLane+1];
    logic [DATA_WIDTH-1:0] w_in;

    assign w_in = r_rdValid ? sram_rdata[gLane*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
        for (int k = 0; k <= gLane; k++) begin
          r_stage[k] <= '0;
        end
      end else if (w_clear) begin
        for (int k = 0; k <= gLane; k++) begin
          r_stage[k] <= '0;
        end
      end else if (w_shift) begin
        r_stage[0] <= w_in;
        for (int k = 1; k <= gLane; k++) begin
          r_stage[k] <= r_stage[k-1];
        end
      end
    end

    assign feed_data[gLane*DATA_WIDTH +: DATA_WIDTH] = r_stage[gLane];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: SRAM word k lane r holds (8k+r) mod 256.
module tb_systolic_skew_feeder;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int LW = 8;

  logic              clk;
  logic              srstn;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [LW-1:0]     len;
  logic              feed_stall;
  logic [AW-1:0]     sram_raddr;
  logic [N*DW-1:0]   sram_rdata;
  logic [N*DW-1:0]   feed_data;
  logic              feed_valid;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  systolic_skew_feeder #(
    .ARRAY_SIZE(N),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .srstn(srstn),
    .start(start),
    .base_addr(base_addr),
    .len(len),
    .feed_stall(feed_stall),
    .sram_raddr(sram_raddr),
    .sram_rdata(sram_rdata),
    .feed_data(feed_data),
    .feed_valid(feed_valid),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle registered-read SRAM model.
  always @(posedge clk) begin
    for (int r = 0; r < N; r++) begin
      sram_rdata[r*DW +: DW] <= 8'((8 * int'(sram_raddr) + r) % 256);
    end
  end

  function automatic logic [N*DW-1:0] expData(input int base, input int l, input int t);
    logic [N*DW-1:0] d;
    int k;
    d = '0;
    for (int r = 0; r < N; r++) begin
      k = t - r;
      if (k >= 0 && k < l) begin
        d[r*DW +: DW] = 8'((8 * ((base + k) % 1024) + r) % 256);
      end
    end
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input int b, input int l, input logic st);
    start      = s;
    base_addr  = AW'(b);
    len        = LW'(l);
    feed_stall = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer and checks every cycle against the wavefront model.
  task automatic doRun(input string tag, input int base, input int l, input int stallAt,
                       input int stallLen, input int extraStartAt);
    int expT;
    int stallUsed;
    int total;
    bit finished;
    bit stallNow;
    bit startNow;
    total     = l + N - 1;
    expT      = -2;
    stallUsed = 0;
    finished  = 1'b0;
    applyStimulus(1'b1, base, l, 1'b0);
    tick();
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      stallNow = (expT == stallAt) && (stallUsed < stallLen);
      if (stallNow) stallUsed++;
      startNow = (cyc == extraStartAt);
      applyStimulus(startNow, startNow ? 500 : base, startNow ? 3 : l, stallNow);
      #1;
      if (expT < total) begin
        checkOutput($sformatf("%s.busy t=%0d", tag, expT), 64'(busy), 64'd1);
        checkOutput($sformatf("%s.done t=%0d", tag, expT), 64'(done), 64'd0);
        checkOutput($sformatf("%s.valid t=%0d", tag, expT), 64'(feed_valid), 64'(expT >= 0));
        checkOutput($sformatf("%s.data t=%0d", tag, expT), feed_data, expData(base, l, expT));
        if (!stallNow && expT + 2 < l) begin
          checkOutput($sformatf("%s.raddr t=%0d", tag, expT), 64'(sram_raddr),
                      64'((base + expT + 2) % 1024));
        end
        if (stallNow && expT >= 0 && expT + 1 < l) begin
          checkOutput($sformatf("%s.stallraddr t=%0d", tag, expT), 64'(sram_raddr),
                      64'((base + expT + 1) % 1024));
        end
      end else if (expT == total) begin
        checkOutput($sformatf("%s.done_pulse", tag), 64'(done), 64'd1);
        checkOutput($sformatf("%s.done_busy", tag), 64'(busy), 64'd1);
        checkOutput($sformatf("%s.done_valid", tag), 64'(feed_valid), 64'd0);
        checkOutput($sformatf("%s.done_data", tag), feed_data, 64'd0);
      end else begin
        checkOutput($sformatf("%s.idle_done", tag), 64'(done), 64'd0);
        checkOutput($sformatf("%s.idle_busy", tag), 64'(busy), 64'd0);
        checkOutput($sformatf("%s.idle_valid", tag), 64'(feed_valid), 64'd0);
        finished = 1'b1;
      end
      if (!stallNow) expT++;
      if (!finished) tick();
    end
    checkOutput($sformatf("%s.completed", tag), 64'(finished), 64'd1);
  endtask

  initial begin
    srstn = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b0);
    #3;
    $display("[TB] reset state");
    checkOutput("rst.raddr", 64'(sram_raddr), 64'd0);
    checkOutput("rst.data", feed_data, 64'd0);
    checkOutput("rst.valid", 64'(feed_valid), 64'd0);
    checkOutput("rst.busy", 64'(busy), 64'd0);
    checkOutput("rst.done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    srstn = 1'b1;
    tick();

    $display("[TB] base run");
    doRun("base", 0, 24, -100, 0, -1);
    tick();

    $display("[TB] stalled run");
    doRun("stall", 0, 24, 5, 3, -1);
    tick();

    $display("[TB] zero length");
    applyStimulus(1'b1, 10, 0, 1'b0);
    tick();
    applyStimulus(1'b0, 10, 0, 1'b0);
    #1;
    checkOutput("zero.done", 64'(done), 64'd1);
    checkOutput("zero.busy", 64'(busy), 64'd1);
    checkOutput("zero.raddr", 64'(sram_raddr), 64'd0);
    checkOutput("zero.valid", 64'(feed_valid), 64'd0);
    tick();
    checkOutput("zero.done_after", 64'(done), 64'd0);
    checkOutput("zero.busy_after", 64'(busy), 64'd0);
    checkOutput("zero.raddr_after", 64'(sram_raddr), 64'd0);
    checkOutput("zero.valid_after", 64'(feed_valid), 64'd0);
    tick();

    $display("[TB] address wrap");
    doRun("wrap", 1020, 8, -100, 0, -1);
    tick();

    $display("[TB] start while busy");
    doRun("busystart", 40, 24, -100, 0, 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("busystart.nodone%0d", i), 64'(done), 64'd0);
      checkOutput($sformatf("busystart.idle%0d", i), 64'(busy), 64'd0);
    end

    $display("[TB] reset mid-drain");
    applyStimulus(1'b1, 0, 24, 1'b0);
    tick();
    applyStimulus(1'b0, 0, 24, 1'b0);
    repeat (26) tick();
    checkOutput("abort.busy_before", 64'(busy), 64'd1);
    checkOutput("abort.valid_before", 64'(feed_valid), 64'd1);
    #1;
    srstn = 1'b0;
    #1;
    checkOutput("abort.raddr", 64'(sram_raddr), 64'd0);
    checkOutput("abort.data", feed_data, 64'd0);
    checkOutput("abort.valid", 64'(feed_valid), 64'd0);
    checkOutput("abort.busy", 64'(busy), 64'd0);
    checkOutput("abort.done", 64'(done), 64'd0);
    tick();
    srstn = 1'b1;
    tick();
    doRun("after_abort", 100, 4, -100, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
